// File: rtl/sim_exit_ctrl.sv
// Simulation exit / kernel-timing peripheral on an OBI responder port.
// Software latches a return value, fires exit, and runs a saturating cycle timer.
module sim_exit_ctrl #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  exit_valid_o,
  output logic [31:0]           exit_value_o,
  output logic                  timer_trig_o
);

  localparam int unsigned WordW = ADDR_WIDTH - 2;
  localparam logic [WordW-1:0] AddrExitValue = WordW'(0);
  localparam logic [WordW-1:0] AddrExitCtrl  = WordW'(1);
  localparam logic [WordW-1:0] AddrTimerCtrl = WordW'(2);
  localparam logic [WordW-1:0] AddrTimerCnt  = WordW'(3);
  localparam logic [WordW-1:0] AddrStatus    = WordW'(4);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} timer_state_e;

  timer_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [31:0]          value_q, value_d;
  logic [31:0]          exit_value_q, exit_value_d;
  logic                 exited_q, exited_d;
  logic                 rvalid_q, rvalid_d;
  logic [31:0]          rdata_q, rdata_d;

  logic [WordW-1:0] word;
  logic             wr_en, rd_en, fire, ctl_wr, start, stop, clr;
  logic [31:0]      rd_data;
  logic             unused_addr;

  assign word        = addr_i[ADDR_WIDTH-1:2];
  assign unused_addr = ^addr_i[1:0];
  assign wr_en       = req_i & we_i;
  assign rd_en       = req_i & ~we_i;

  // Only the first fire counts; exit state is frozen until reset afterwards.
  assign fire   = wr_en & (word == AddrExitCtrl) & be_i[0] & wdata_i[0] & ~exited_q;
  assign ctl_wr = wr_en & (word == AddrTimerCtrl) & be_i[0];
  assign stop   = ctl_wr & wdata_i[1];
  assign start  = ctl_wr & wdata_i[0] & ~wdata_i[1];
  assign clr    = ctl_wr & wdata_i[2];

  always_comb begin
    value_d = value_q;
    if (wr_en && (word == AddrExitValue)) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) value_d[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
    exited_d     = exited_q | fire;
    exit_value_d = fire ? value_q : exit_value_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (clr) begin
          cnt_d = '0;
          ovf_d = 1'b0;
        end
      end
      StRun: begin
        if (clr) begin
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (cnt_q == CntMax) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (stop || fire) state_d = StDone;
      end
      StDone: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (clr) begin
          state_d = StIdle;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (word)
      AddrExitValue: rd_data = value_q;
      AddrExitCtrl:  rd_data = {31'b0, exited_q};
      AddrTimerCnt:  rd_data[CNT_WIDTH-1:0] = cnt_q;
      AddrStatus:    rd_data = {29'b0, ovf_q, exited_q, state_q == StRun};
      default:       rd_data = '0;
    endcase
    rvalid_d = req_i;
    rdata_d  = rd_en ? rd_data : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      value_q      <= '0;
      exit_value_q <= '0;
      exited_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      value_q      <= value_d;
      exit_value_q <= exit_value_d;
      exited_q     <= exited_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign gnt_o        = req_i;
  assign rvalid_o     = rvalid_q;
  assign rdata_o      = rdata_q;
  assign exit_valid_o = exited_q;
  assign exit_value_o = exit_value_q;
  assign timer_trig_o = (state_q == StRun);

endmodule

// File: tb/tb_sim_exit_ctrl.sv
// Bench for sim_exit_ctrl: 32-bit and 8-bit counter instances share one bus stimulus
// and are checked every cycle against an elapsed-time model, plus directed literal checks.
module tb_sim_exit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [4:0]  addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;

  logic        gnt32, rvalid32, xvalid32, trig32;
  logic [31:0] rdata32, xvalue32;
  logic        gnt8, rvalid8, xvalid8, trig8;
  logic [31:0] rdata8, xvalue8;

  always #5 clk = ~clk;

  sim_exit_ctrl #(.ADDR_WIDTH(5), .CNT_WIDTH(32)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt32), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid32), .rdata_o(rdata32),
    .exit_valid_o(xvalid32), .exit_value_o(xvalue32), .timer_trig_o(trig32)
  );

  sim_exit_ctrl #(.ADDR_WIDTH(5), .CNT_WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt8), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid8), .rdata_o(rdata8),
    .exit_valid_o(xvalid8), .exit_value_o(xvalue8), .timer_trig_o(trig8)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  localparam int MIdle = 0, MRun = 1, MDone = 2;

  // Model: timer tracked as unbounded elapsed cycles; saturation derived per width.
  logic [31:0] m_val, m_exv, m_rd32, m_rd8;
  bit          m_exited, m_rvalid;
  int          m_mode;
  longint      m_el;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_val = '0; m_exv = '0; m_rd32 = '0; m_rd8 = '0;
    m_exited = 1'b0; m_rvalid = 1'b0; m_mode = MIdle; m_el = 0;
  endtask

  function automatic logic [31:0] m_read(input int w, input logic [2:0] wd);
    longint mx = (longint'(1) << w) - 1;
    longint c = (m_el > mx) ? mx : m_el;
    case (wd)
      3'd0: return m_val;
      3'd1: return {31'b0, m_exited};
      3'd3: return c[31:0];
      3'd4: return {29'b0, (m_el > mx), m_exited, (m_mode == MRun)};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic [2:0] wd = addr[4:2];
    bit wr = req && we;
    bit fire = wr && wd == 3'd1 && be[0] && wdata[0] && !m_exited;
    bit cw = wr && wd == 3'd2 && be[0];
    bit sp = cw && wdata[1];
    bit st = cw && wdata[0] && !wdata[1];
    bit cl = cw && wdata[2];
    m_rvalid = req;
    m_rd32 = (req && !we) ? m_read(32, wd) : 32'h0;
    m_rd8  = (req && !we) ? m_read(8, wd) : 32'h0;
    if (fire) begin
      m_exv = m_val;
      m_exited = 1'b1;
    end
    if (wr && wd == 3'd0) begin
      for (int b = 0; b < 4; b++) if (be[b]) m_val[8*b +: 8] = wdata[8*b +: 8];
    end
    if (m_mode == MIdle) begin
      if (st) begin m_mode = MRun; m_el = 0; end
    end else if (m_mode == MRun) begin
      m_el = cl ? 0 : m_el + 1;
      if (sp || fire) m_mode = MDone;
    end else begin
      if (st) begin m_mode = MRun; m_el = 0; end
      else if (cl) begin m_mode = MIdle; m_el = 0; end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt32", {31'b0, gnt32}, {31'b0, req});
      chk("gnt8", {31'b0, gnt8}, {31'b0, req});
      chk("rvalid32", {31'b0, rvalid32}, {31'b0, m_rvalid});
      chk("rvalid8", {31'b0, rvalid8}, {31'b0, m_rvalid});
      chk("rdata32", rdata32, m_rd32);
      chk("rdata8", rdata8, m_rd8);
      chk("exit_valid32", {31'b0, xvalid32}, {31'b0, m_exited});
      chk("exit_valid8", {31'b0, xvalid8}, {31'b0, m_exited});
      chk("exit_value32", xvalue32, m_exv);
      chk("exit_value8", xvalue8, m_exv);
      chk("trig32", {31'b0, trig32}, {31'b0, m_mode == MRun});
      chk("trig8", {31'b0, trig8}, {31'b0, m_mode == MRun});
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic op(input bit w, input logic [4:0] a, input logic [3:0] b,
                    input logic [31:0] d, output logic [31:0] r32, output logic [31:0] r8);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    tick();
    req = 1'b0; we = 1'b0;
    r32 = rdata32;
    r8  = rdata8;
  endtask

  task automatic assert_reset(input int n);
    req = 1'b0; we = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r32, r8;
    model_reset();
    chk_en = 1'b1;
    #1;
    repeat (3) tick();
    chk("rst_exit_valid", {31'b0, xvalid32}, 32'h0);
    chk("rst_trig", {31'b0, trig32}, 32'h0);
    chk("rst_rvalid", {31'b0, rvalid32}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Partial byte write, unmapped read, start+stop no-op from idle
    op(1'b1, 5'h00, 4'b0010, 32'hAABBCCDD, r32, r8);
    op(1'b0, 5'h00, 4'hF, 32'h0, r32, r8);
    chk("be_write", r32, 32'h0000CC00);
    chk("exit_value_pre", xvalue32, 32'h0);
    op(1'b0, 5'h1C, 4'hF, 32'h0, r32, r8);
    chk("unmapped_rd", r32, 32'h0);
    op(1'b1, 5'h08, 4'h1, 32'h3, r32, r8);
    chk("wr_rdata_zero", r32, 32'h0);
    op(1'b0, 5'h10, 4'hF, 32'h0, r32, r8);
    chk("startstop_noop", r32, 32'h0);

    // Start, 100 idle cycles, stop: count equals grant distance and stays frozen
    op(1'b1, 5'h08, 4'h1, 32'h1, r32, r8);
    chk("trig_after_start", {31'b0, trig32}, 32'h1);
    repeat (100) tick();
    op(1'b1, 5'h08, 4'h1, 32'h2, r32, r8);
    chk("trig_after_stop", {31'b0, trig32}, 32'h0);
    op(1'b0, 5'h0C, 4'hF, 32'h0, r32, r8);
    chk("count_101", r32, 32'd101);
    repeat (5) tick();
    op(1'b0, 5'h0C, 4'hF, 32'h0, r32, r8);
    chk("count_frozen", r32, 32'd101);

    // Restart from DONE and let the 8-bit instance saturate
    op(1'b1, 5'h08, 4'h1, 32'h1, r32, r8);
    repeat (300) tick();
    op(1'b0, 5'h0C, 4'hF, 32'h0, r32, r8);
    chk("count8_sat", r8, 32'hFF);
    chk("count32_300", r32, 32'd300);
    op(1'b0, 5'h10, 4'hF, 32'h0, r32, r8);
    chk("status8_ovf", r8, 32'h5);
    chk("status32_run", r32, 32'h1);
    op(1'b1, 5'h08, 4'h1, 32'h4, r32, r8);
    op(1'b0, 5'h10, 4'hF, 32'h0, r32, r8);
    chk("status8_clr", r8, 32'h1);
    op(1'b0, 5'h0C, 4'hF, 32'h0, r32, r8);
    chk("count8_clr", r8, 32'h1);

    // Exit fire while running freezes the timer; later start still accepted
    repeat (50) tick();
    op(1'b1, 5'h00, 4'hF, 32'h0000002A, r32, r8);
    op(1'b1, 5'h04, 4'h1, 32'h1, r32, r8);
    chk("exit_valid", {31'b0, xvalid32}, 32'h1);
    chk("exit_value", xvalue32, 32'd42);
    chk("trig_at_exit", {31'b0, trig32}, 32'h0);
    op(1'b0, 5'h10, 4'hF, 32'h0, r32, r8);
    chk("status_exited", r32, 32'h2);
    op(1'b1, 5'h00, 4'hF, 32'h55, r32, r8);
    op(1'b1, 5'h04, 4'h1, 32'h1, r32, r8);
    tick();
    chk("exit_value_sticky", xvalue32, 32'd42);
    op(1'b1, 5'h08, 4'h1, 32'h1, r32, r8);
    op(1'b0, 5'h10, 4'hF, 32'h0, r32, r8);
    chk("restart_after_exit", r32, 32'h3);

    // Reset with a response pending, exit set and timer running
    req = 1'b1; we = 1'b0; addr = 5'h10; be = 4'hF;
    tick();
    chk("pending_rvalid", {31'b0, rvalid32}, 32'h1);
    assert_reset(2);
    chk("reset_exit_valid", {31'b0, xvalid32}, 32'h0);
    chk("reset_rvalid", {31'b0, rvalid32}, 32'h0);
    tick();
    chk("post_reset_rvalid", {31'b0, rvalid32}, 32'h0);
    op(1'b0, 5'h10, 4'hF, 32'h0, r32, r8);
    chk("post_reset_status", r32, 32'h0);

    // Randomized traffic with periodic resets
    for (int i = 0; i < 3000; i++) begin
      int unsigned sel;
      if (i % 700 == 699) begin
        assert_reset(1 + int'($urandom_range(2)));
      end
      sel = $urandom_range(15);
      req = ($urandom_range(1) == 1);
      we = ($urandom_range(1) == 1);
      be = 4'($urandom);
      if (sel < 4) addr = 5'h00;
      else if (sel == 4) addr = 5'h04;
      else if (sel == 5) addr = 5'h08;
      else if (sel < 9) addr = 5'h0C;
      else if (sel < 12) addr = 5'h10;
      else addr = 5'($urandom_range(31));
      wdata = (sel == 5 || sel == 4) ? 32'($urandom_range(7)) : $urandom;
      tick();
    end
    req = 1'b0; we = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
